decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/isa_pkg.sv | 76 +++++++
 rtl/decode_stage_if.sv | 33 +++
 rtl/decode_stage.sv | 82 ++++++++
 tb/tb_decode_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode constants, the decoded control word and the
// combinational opcode decoder used by the decode stage.
package isa_pkg;

    localparam logic [7:0] OP_ALU_LO = 8'h80;
    localparam logic [7:0] OP_DIV    = 8'h83;
    localparam logic [7:0] OP_ALU_HI = 8'h87;
    localparam logic [7:0] OP_ILL    = 8'h88;
    localparam logic [7:0] OP_NOP_LO = 8'h89;
    localparam logic [7:0] OP_NOP_HI = 8'h8E;
    localparam logic [7:0] OP_STORE  = 8'h8F;
    localparam logic [7:0] OP_BRANCH = 8'h90;
    localparam logic [7:0] OP_LOAD   = 8'h9F;
    localparam logic [7:0] OP_IMM    = 8'hA0;
    localparam logic [7:0] OP_JUMP   = 8'hB0;

    typedef enum logic [1:0] {
        OPC_LEGAL    = 2'd0,
        OPC_UNLISTED = 2'd1,
        OPC_WIDE     = 2'd2
    } opClass_e;

    typedef struct packed {
        logic j;
        logic b;
        logic mem;
        logic store;
        logic div;
        logic im;
        logic mwe;
        logic mux;
        logic rwe;
    } ctrl_t;

    typedef struct packed {
        ctrl_t    ctrl;
        opClass_e opClass;
    } decode_t;

    // upperSet means some opcode bit above bit 7 is 1, which never matches the table.
    function automatic decode_t decodeOp(input logic [7:0] op, input logic upperSet);
        decode_t d;
        d = '0;
        if (upperSet) begin
            d.opClass = OPC_WIDE;
        end else begin
            case (op)
                8'h80, 8'h81, 8'h82, 8'h84, 8'h85, 8'h86, 8'h87: d.ctrl.rwe = 1'b1;
                OP_DIV: begin
                    d.ctrl.div = 1'b1;
                    d.ctrl.rwe = 1'b1;
                end
                8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E: d.ctrl = '0;
                OP_STORE: begin
                    d.ctrl.mem   = 1'b1;
                    d.ctrl.store = 1'b1;
                    d.ctrl.mwe   = 1'b1;
                end
                OP_LOAD: begin
                    d.ctrl.mem = 1'b1;
                    d.ctrl.mux = 1'b1;
                    d.ctrl.rwe = 1'b1;
                end
                OP_BRANCH: d.ctrl.b = 1'b1;
                OP_JUMP:   d.ctrl.j = 1'b1;
                OP_IMM: begin
                    d.ctrl.im  = 1'b1;
                    d.ctrl.rwe = 1'b1;
                end
                default: d.opClass = OPC_UNLISTED;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and control-word bundle between the fetch side, the decode stage
// and the execute side.
interface decode_stage_if #(
    parameter int OP_W = 8
);
    logic            In_Valid;
    logic [OP_W-1:0] In_Code;
    logic            In_Ready;
    logic            Flush;
    logic            Out_Valid;
    logic            Out_Ready;
    logic            J;
    logic            B;
    logic            Mem;
    logic            Store;
    logic            Div;
    logic            Im;
    logic            MWE;
    logic            Mux;
    logic            RWE;
    logic            Illegal;
    logic            Busy;

    modport master (
        output In_Valid, In_Code, Flush, Out_Ready,
        input  In_Ready, Out_Valid, J, B, Mem, Store, Div, Im, MWE, Mux, RWE, Illegal, Busy
    );

    modport slave (
        input  In_Valid, In_Code, Flush, Out_Ready,
        output In_Ready, Out_Valid, J, B, Mem, Store, Div, Im, MWE, Mux, RWE, Illegal, Busy
    );
endinterface

// File: rtl/decode_stage.sv
// Single-register decode stage: opcode -> control word with a valid/ready
// handshake, flush, and an issue stall after every accepted divide.
module decode_stage
    import isa_pkg::*;
#(
    parameter int OP_W    = 8,
    parameter int DIV_LAT = 4
) (
    input logic          clk,
    input logic          rst,
    decode_stage_if.slave bus
);

    localparam int CNT_W = (DIV_LAT > 0) ? $clog2(DIV_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_divCnt;
    logic             r_outValid;
    logic             r_illegal;
    ctrl_t            r_ctrl;

    logic    w_upperSet;
    logic    w_inReady;
    logic    w_accept;
    decode_t w_dec;

    generate
        if (OP_W > 8) begin : g_wide
            assign w_upperSet = |bus.In_Code[OP_W-1:8];
        end else begin : g_narrow
            assign w_upperSet = 1'b0;
        end
    endgenerate

    assign w_dec     = decodeOp(bus.In_Code[7:0], w_upperSet);
    assign w_inReady = !bus.Flush && (r_divCnt == '0) && (!r_outValid || bus.Out_Ready);
    assign w_accept  = bus.In_Valid && w_inReady;

    // The stall counter only loads when idle (accept implies zero), and flush never touches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divCnt <= '0;
        end else if (w_accept && w_dec.ctrl.div) begin
            r_divCnt <= DIV_LOAD;
        end else if (r_divCnt != '0) begin
            r_divCnt <= r_divCnt - CNT_ONE;
        end
    end

    // Flush outranks both a new accept and a downstream consume.
    always_ff @(posedge clk) begin
        if (rst || bus.Flush) begin
            r_outValid <= 1'b0;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_outValid <= 1'b1;
            r_ctrl     <= w_dec.ctrl;
            r_illegal  <= (w_dec.opClass != OPC_LEGAL);
        end else if (r_outValid && bus.Out_Ready) begin
            r_outValid <= 1'b0;
            r_ctrl     <= '0;
            r_illegal  <= 1'b0;
        end
    end

    assign bus.In_Ready  = w_inReady;
    assign bus.Out_Valid = r_outValid;
    assign bus.J         = r_ctrl.j;
    assign bus.B         = r_ctrl.b;
    assign bus.Mem       = r_ctrl.mem;
    assign bus.Store     = r_ctrl.store;
    assign bus.Div       = r_ctrl.div;
    assign bus.Im        = r_ctrl.im;
    assign bus.MWE       = r_ctrl.mwe;
    assign bus.Mux       = r_ctrl.mux;
    assign bus.RWE       = r_ctrl.rwe;
    assign bus.Illegal   = r_illegal;
    assign bus.Busy      = (r_divCnt != '0);

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus a random phase, scored
// against a cycle-numbered transaction model of the stage.
module tb_decode_stage;

    localparam int DIV_LAT = 4;

    logic clk;
    logic rst;

    decode_stage_if #(.OP_W(8))  bus8 ();
    decode_stage_if #(.OP_W(10)) bus10 ();

    decode_stage #(.OP_W(8), .DIV_LAT(DIV_LAT)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    decode_stage #(.OP_W(10), .DIV_LAT(DIV_LAT)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (bus10.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model: registered output word plus the cycle number at which the divide stall ends.
    int         cycNow   = 0;
    int         stallEnd = 0;
    logic       mValid   = 1'b0;
    logic [9:0] mWord    = '0;

    // Expected {Illegal, J, B, Mem, Store, Div, Im, MWE, Mux, RWE} for an opcode value.
    function automatic logic [9:0] refDecode(input int code);
        if (code >= 'h80 && code <= 'h87 && code != 'h83) return 10'b0_000000001;
        if (code == 'h83)                                return 10'b0_000010001;
        if (code >= 'h89 && code <= 'h8E)                return 10'b0_000000000;
        if (code == 'h8F)                                return 10'b0_001100100;
        if (code == 'h9F)                                return 10'b0_001000011;
        if (code == 'h90)                                return 10'b0_010000000;
        if (code == 'hB0)                                return 10'b0_100000000;
        if (code == 'hA0)                                return 10'b0_000001001;
        return 10'b1_000000000;
    endfunction

    function automatic logic [9:0] word8();
        return {bus8.Illegal, bus8.J, bus8.B, bus8.Mem, bus8.Store, bus8.Div,
                bus8.Im, bus8.MWE, bus8.Mux, bus8.RWE};
    endfunction

    function automatic logic [9:0] word10();
        return {bus10.Illegal, bus10.J, bus10.B, bus10.Mem, bus10.Store, bus10.Div,
                bus10.Im, bus10.MWE, bus10.Mux, bus10.RWE};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s at t=%0t: observed %h expected %h", tag, $time, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] code,
                                 input logic fl, input logic ordy);
        logic       busy;
        logic       ready;
        logic       acc;
        logic [9:0] dec;
        rst            = r;
        bus8.In_Valid  = v;
        bus8.In_Code   = code;
        bus8.Flush     = fl;
        bus8.Out_Ready = ordy;
        #1;
        busy  = (cycNow < stallEnd);
        ready = !fl && !busy && (!mValid || ordy);
        if (!r) checkOutput("in_ready", 32'(bus8.In_Ready), 32'(ready));
        acc = v && ready;
        dec = refDecode(int'(code));
        if (r || fl) begin
            mValid = 1'b0;
            mWord  = '0;
            if (r) stallEnd = 0;
        end else if (acc) begin
            mValid = 1'b1;
            mWord  = dec;
            if (dec[4]) stallEnd = cycNow + 1 + DIV_LAT;
        end else if (mValid && ordy) begin
            mValid = 1'b0;
            mWord  = '0;
        end
        @(posedge clk);
        cycNow++;
        #1;
        checkOutput("out_valid", 32'(bus8.Out_Valid), 32'(mValid));
        checkOutput("ctrl_word", 32'(word8()), 32'(mWord));
        checkOutput("busy", 32'(bus8.Busy), 32'(cycNow < stallEnd));
    endtask

    initial begin
        logic [7:0] pool [16];
        logic [7:0] code;
        pool = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h86, 8'h87, 8'h88,
                 8'h89, 8'h8E, 8'h8F, 8'h9F, 8'h90, 8'hB0, 8'hA0, 8'h00};

        bus10.In_Valid  = 1'b0;
        bus10.In_Code   = '0;
        bus10.Flush     = 1'b0;
        bus10.Out_Ready = 1'b1;

        // Reset, then a plain ALU op streaming through.
        applyStimulus(1, 0, 8'h00, 0, 1);
        applyStimulus(1, 1, 8'h83, 1, 1);
        applyStimulus(0, 1, 8'h80, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Divide followed by a waiting op through the whole stall window.
        applyStimulus(0, 1, 8'h83, 0, 1);
        for (int i = 0; i < DIV_LAT + 2; i++) applyStimulus(0, 1, 8'h80, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Store held by backpressure while a load waits.
        applyStimulus(0, 1, 8'h8F, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h9F, 0, 0);
        applyStimulus(0, 1, 8'h9F, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Unlisted opcode on the narrow stage.
        applyStimulus(0, 1, 8'h88, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // Wide stage: any bit above bit 7 makes the opcode illegal.
        bus10.In_Valid = 1'b1;
        bus10.In_Code  = 10'h180;
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("w10_valid", 32'(bus10.Out_Valid), 32'd1);
        checkOutput("w10_word_180", 32'(word10()), 32'h200);
        bus10.In_Code  = 10'h0A0;
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("w10_word_0a0", 32'(word10()), 32'h009);
        bus10.In_Code  = 10'h2A0;
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("w10_word_2a0", 32'(word10()), 32'h200);
        bus10.In_Valid = 1'b0;
        applyStimulus(0, 0, 8'h00, 0, 1);
        checkOutput("w10_drain", 32'(bus10.Out_Valid), 32'd0);

        // Branch held, then flushed together with an incoming jump.
        applyStimulus(0, 1, 8'h90, 0, 0);
        applyStimulus(0, 1, 8'hB0, 1, 0);
        applyStimulus(0, 0, 8'h00, 0, 1);

        // A flushed divide keeps its stall.
        applyStimulus(0, 1, 8'h83, 0, 0);
        applyStimulus(0, 0, 8'h00, 1, 0);
        applyStimulus(0, 1, 8'h80, 0, 1);
        for (int i = 0; i < DIV_LAT; i++) applyStimulus(0, 0, 8'h00, 0, 1);

        // Reset aborts an in-flight divide stall.
        applyStimulus(0, 1, 8'h83, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 1);
        applyStimulus(1, 0, 8'h00, 0, 1);
        applyStimulus(0, 1, 8'hA0, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 1);

        for (int i = 0; i < 400; i++) begin
            code = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 15)];
            applyStimulus(($urandom_range(0, 63) == 0), 1'($urandom), code,
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
